countdown_timer: RTL

BCD countdown timer for the board's M:SS.d display. It is the counterpart of the up-counting stopwatch. A preset (1-digit minutes, 2-digit seconds, tenths) is loaded, then decremented by one tenth per tick. It stops at 0:00.0 and flags expiry, or optionally reloads. Outputs drive the same 4-digit 7-segment scan logic as the stopwatch.

---
 rtl/countdown_timer_pkg.sv | 28 ++
 rtl/bcd_down_digit.sv | 40 ++++
 rtl/countdown_timer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer slice.
// Contents:
//   DIGIT_W           - width of one BCD digit
//   DEFAULT_DIGIT_MAX - borrow reload value for min1/sec1/ms100
//   DEFAULT_SEC10_MAX - borrow reload value for the tens-of-seconds digit
//   state_t           - controller states IDLE/RUN/PAUSE/DONE
//   sat_digit         - clamps a preset digit to its legal maximum
package countdown_timer_pkg;

  localparam int DIGIT_W           = 4;
  localparam int DEFAULT_DIGIT_MAX = 9;
  localparam int DEFAULT_SEC10_MAX = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Out-of-range preset digits are stored as the digit maximum so the
  // counter can never hold a non-BCD value.
  function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] d,
                                                   input logic [DIGIT_W-1:0] max_val);
    return (d > max_val) ? max_val : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with synchronous load.
// Ports:
//   clk        - system clock
//   clr        - asynchronous active-high reset, clears the digit
//   load       - capture in_load on the next edge (wins over dec_en)
//   in_load    - value to load
//   dec_en     - decrement by one; at zero the digit wraps to MAX
//   q          - current digit value
//   borrow_out - high when this digit wraps (q==0 and dec_en), feeds the
//                next more significant digit's dec_en
module bcd_down_digit
  import countdown_timer_pkg::*;
#(
  parameter int MAX = DEFAULT_DIGIT_MAX
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] in_load,
  input  logic               dec_en,
  output logic [DIGIT_W-1:0] q,
  output logic               borrow_out
);

  localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MAX);

  // Digit register: load has priority, otherwise decrement with wrap.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= in_load;
    end else if (dec_en) begin
      q <= (q == '0) ? MAX_V : q - 1'b1;
    end
  end

  assign borrow_out = dec_en && (q == '0);

endmodule

// File: rtl/countdown_timer.sv
// BCD countdown timer for the M:SS.d display.
// Ports:
//   clk, clr                     - clock, asynchronous active-high reset
//   tick                         - one-cycle pulse every 100 ms
//   load/start/stop              - synchronous controls, priority load>stop>start>tick
//   in_min1/in_sec10/in_sec1/in_ms100 - preset digits (saturated on load)
//   min1/sec1/sec10/ms100        - current count digits
//   running                      - high in RUN
//   done                         - high in DONE
//   expired                      - one-cycle pulse when the count reaches 0:00.0
// With AUTO_RELOAD=1 the timer stays in RUN after expiry and the next tick
// reloads the stored preset instead of decrementing.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int AUTO_RELOAD = 0,
  parameter int SEC10_MAX   = DEFAULT_SEC10_MAX,
  parameter int DIGIT_MAX   = DEFAULT_DIGIT_MAX
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               tick,
  input  logic               load,
  input  logic               start,
  input  logic               stop,
  input  logic [DIGIT_W-1:0] in_min1,
  input  logic [DIGIT_W-1:0] in_sec10,
  input  logic [DIGIT_W-1:0] in_sec1,
  input  logic [DIGIT_W-1:0] in_ms100,
  output logic [DIGIT_W-1:0] min1,
  output logic [DIGIT_W-1:0] sec10,
  output logic [DIGIT_W-1:0] sec1,
  output logic [DIGIT_W-1:0] ms100,
  output logic               running,
  output logic               done,
  output logic               expired
);

  localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(DIGIT_MAX);
  localparam logic [DIGIT_W-1:0] SMAX = DIGIT_W'(SEC10_MAX);

  state_t state, state_next;

  logic [DIGIT_W-1:0] pre_min1, pre_sec10, pre_sec1, pre_ms100;
  logic [DIGIT_W-1:0] sat_min1, sat_sec10, sat_sec1, sat_ms100;
  logic [DIGIT_W-1:0] ld_min1, ld_sec10, ld_sec1, ld_ms100;

  logic dec_en, reload, expire_next, digit_load;
  logic count_zero, count_one;
  logic ms_borrow, s1_borrow, s10_borrow, min1_borrow_unused;

  assign sat_min1  = sat_digit(in_min1, DMAX);
  assign sat_sec10 = sat_digit(in_sec10, SMAX);
  assign sat_sec1  = sat_digit(in_sec1, DMAX);
  assign sat_ms100 = sat_digit(in_ms100, DMAX);

  assign count_zero = (min1 == '0) && (sec10 == '0) && (sec1 == '0) && (ms100 == '0);
  assign count_one  = (min1 == '0) && (sec10 == '0) && (sec1 == '0) && (ms100 == 4'd1);

  // Preset register, remembered for auto-reload.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pre_min1  <= '0;
      pre_sec10 <= '0;
      pre_sec1  <= '0;
      pre_ms100 <= '0;
    end else if (load) begin
      pre_min1  <= sat_min1;
      pre_sec10 <= sat_sec10;
      pre_sec1  <= sat_sec1;
      pre_ms100 <= sat_ms100;
    end
  end

  // State register and the one-cycle expiry pulse.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= ST_IDLE;
      expired <= 1'b0;
    end else begin
      state   <= state_next;
      expired <= expire_next;
    end
  end

  // Next-state logic. The if/else chain encodes control priority; a start
  // that does not apply (e.g. in RUN) falls through so a tick still counts.
  // A zero count in RUN only happens after an auto-reload expiry, since
  // start refuses a zero count.
  always_comb begin
    state_next  = state;
    dec_en      = 1'b0;
    reload      = 1'b0;
    expire_next = 1'b0;
    if (load) begin
      state_next = ST_IDLE;
    end else if (stop) begin
      if (state == ST_RUN) state_next = ST_PAUSE;
    end else if (start && (state == ST_IDLE || state == ST_PAUSE)) begin
      if (!count_zero) state_next = ST_RUN;
    end else if (tick && state == ST_RUN) begin
      if (count_zero) begin
        reload = (AUTO_RELOAD != 0);
      end else begin
        dec_en = 1'b1;
        if (count_one) begin
          expire_next = 1'b1;
          if (AUTO_RELOAD == 0) state_next = ST_DONE;
        end
      end
    end
  end

  assign digit_load = load || reload;
  assign ld_min1    = load ? sat_min1  : pre_min1;
  assign ld_sec10   = load ? sat_sec10 : pre_sec10;
  assign ld_sec1    = load ? sat_sec1  : pre_sec1;
  assign ld_ms100   = load ? sat_ms100 : pre_ms100;

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_ms100 (
    .clk(clk), .clr(clr), .load(digit_load), .in_load(ld_ms100),
    .dec_en(dec_en), .q(ms100), .borrow_out(ms_borrow)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_sec1 (
    .clk(clk), .clr(clr), .load(digit_load), .in_load(ld_sec1),
    .dec_en(ms_borrow), .q(sec1), .borrow_out(s1_borrow)
  );

  bcd_down_digit #(.MAX(SEC10_MAX)) u_sec10 (
    .clk(clk), .clr(clr), .load(digit_load), .in_load(ld_sec10),
    .dec_en(s1_borrow), .q(sec10), .borrow_out(s10_borrow)
  );

  // The minutes borrow never fires: decrement is blocked at 0:00.0.
  bcd_down_digit #(.MAX(DIGIT_MAX)) u_min1 (
    .clk(clk), .clr(clr), .load(digit_load), .in_load(ld_min1),
    .dec_en(s10_borrow), .q(min1), .borrow_out(min1_borrow_unused)
  );

  assign running = (state == ST_RUN);
  assign done    = (state == ST_DONE);

endmodule
